// File: rtl/reg_to_axi_lite.sv
// Regbus-to-AXI4-Lite initiator bridge; one single-beat transaction in flight at a time.
// Define REG_TO_AXI_LITE_ERR_RESP_EN to map SLVERR/DECERR responses onto reg_rsp_o.error.

package reg_to_axi_lite_pkg;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [2:0]    prot;
    } ax_chan_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
    } w_chan_t;

    typedef struct packed {
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_lite_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        logic    ar_ready;
        r_chan_t r;
        logic    r_valid;
    } axi_lite_rsp_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          write;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
        logic          valid;
    } reg_req_t;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          error;
        logic          ready;
    } reg_rsp_t;

endpackage

module reg_to_axi_lite #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter type axi_lite_req_t = reg_to_axi_lite_pkg::axi_lite_req_t,
    parameter type axi_lite_rsp_t = reg_to_axi_lite_pkg::axi_lite_rsp_t,
    parameter type reg_req_t      = reg_to_axi_lite_pkg::reg_req_t,
    parameter type reg_rsp_t      = reg_to_axi_lite_pkg::reg_rsp_t
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  reg_req_t      reg_req_i,
    output reg_rsp_t      reg_rsp_o,
    output axi_lite_req_t axi_lite_req_o,
    input  axi_lite_rsp_t axi_lite_rsp_i
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    if ((DATA_WIDTH != 32) && (DATA_WIDTH != 64)) begin : g_bad_data_width
        $error("reg_to_axi_lite: DATA_WIDTH must be 32 or 64");
    end

    // IDLE wait for req | WR_REQ drive AW/W | WR_RESP wait B | RD_REQ drive AR | RD_RESP wait R
    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP
    } state_e;

    state_e                  state_q,    state_d;
    logic [ADDR_WIDTH-1:0]   addr_q,     addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,    wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q,    wstrb_d;
    logic                    write_q,    write_d;
    logic                    aw_valid_q, aw_valid_d;
    logic                    w_valid_q,  w_valid_d;
    logic                    ar_valid_q, ar_valid_d;
    logic                    aw_done_q,  aw_done_d;
    logic                    w_done_q,   w_done_d;

    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic wr_done;
    logic rd_done;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            write_q    <= 1'b0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            write_q    <= write_d;
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            ar_valid_q <= ar_valid_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        write_d    = write_q;
        aw_valid_d = aw_valid_q;
        w_valid_d  = w_valid_q;
        ar_valid_d = ar_valid_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;

        aw_hs = aw_valid_q & axi_lite_rsp_i.aw_ready;
        w_hs  = w_valid_q  & axi_lite_rsp_i.w_ready;
        ar_hs = ar_valid_q & axi_lite_rsp_i.ar_ready;

        unique case (state_q)
            IDLE: begin
                if (reg_req_i.valid) begin
                    addr_d    = reg_req_i.addr;
                    wdata_d   = reg_req_i.wdata;
                    wstrb_d   = reg_req_i.wstrb;
                    write_d   = reg_req_i.write;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (reg_req_i.write) begin
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                        state_d    = WR_REQ;
                    end else begin
                        ar_valid_d = 1'b1;
                        state_d    = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                if (aw_hs) begin
                    aw_valid_d = 1'b0;
                    aw_done_d  = 1'b1;
                end
                if (w_hs) begin
                    w_valid_d = 1'b0;
                    w_done_d  = 1'b1;
                end
                // Include this cycle's handshakes so a same-cycle AW+W finish costs no extra cycle.
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (axi_lite_rsp_i.b_valid) begin
                    state_d = IDLE;
                end
            end
            RD_REQ: begin
                if (ar_hs) begin
                    ar_valid_d = 1'b0;
                    state_d    = RD_RESP;
                end
            end
            RD_RESP: begin
                if (axi_lite_rsp_i.r_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign wr_done = (state_q == WR_RESP) && axi_lite_rsp_i.b_valid;
    assign rd_done = (state_q == RD_RESP) && axi_lite_rsp_i.r_valid && !write_q;

    always_comb begin
        axi_lite_req_o          = '0;
        axi_lite_req_o.aw.addr  = addr_q;
        axi_lite_req_o.aw.prot  = 3'b000;
        axi_lite_req_o.aw_valid = aw_valid_q;
        axi_lite_req_o.w.data   = wdata_q;
        axi_lite_req_o.w.strb   = wstrb_q;
        axi_lite_req_o.w_valid  = w_valid_q;
        axi_lite_req_o.b_ready  = (state_q == WR_RESP);
        axi_lite_req_o.ar.addr  = addr_q;
        axi_lite_req_o.ar.prot  = 3'b000;
        axi_lite_req_o.ar_valid = ar_valid_q;
        axi_lite_req_o.r_ready  = (state_q == RD_RESP);

        reg_rsp_o       = '0;
        reg_rsp_o.ready = wr_done | rd_done;
        if (rd_done) begin
            reg_rsp_o.rdata = axi_lite_rsp_i.r.data;
        end
`ifdef REG_TO_AXI_LITE_ERR_RESP_EN
        if (wr_done) begin
            reg_rsp_o.error = axi_lite_rsp_i.b.resp[1];
        end
        if (rd_done) begin
            reg_rsp_o.error = axi_lite_rsp_i.r.resp[1];
        end
`endif
    end

`ifndef REG_TO_AXI_LITE_ERR_RESP_EN
    logic unused_resp;
    assign unused_resp = ^{axi_lite_rsp_i.b.resp, axi_lite_rsp_i.r.resp};
`endif

endmodule

// File: doc/reg_to_axi_lite.md
Name: reg_to_axi_lite

Overview:
Register-interface-to-AXI4-Lite bridge, the initiator-side counterpart of the AXI-to-register path. A regbus master (core peripheral port, debug module) issues single reads and writes. The block turns each one into one AXI4-Lite transaction and returns the B/R result as the regbus response. One transaction is outstanding at a time; there is no pipelining.

Parameters:
ADDR_WIDTH, 32, address width of both regbus and AXI-Lite.
DATA_WIDTH, 32, data width of both sides; must be 32 or 64; strobe width is DATA_WIDTH/8.
axi_lite_req_t, logic, AXI-Lite request struct (aw, aw_valid, w, w_valid, b_ready, ar, ar_valid, r_ready).
axi_lite_rsp_t, logic, AXI-Lite response struct (aw_ready, w_ready, b, b_valid, ar_ready, r, r_valid).
reg_req_t, logic, regbus request struct (addr, write, wdata, wstrb, valid).
reg_rsp_t, logic, regbus response struct (rdata, error, ready).

Ports:
clk_i  in  1  clock; one clock domain.
rst_i  in  1  reset; synchronous, active-high.
reg_req_i  in  reg_req_t  regbus request from the upstream master.
reg_rsp_o  out  reg_rsp_t  regbus response to the upstream master.
axi_lite_req_o  out  axi_lite_req_t  AXI-Lite request to the downstream slave.
axi_lite_rsp_i  in  axi_lite_rsp_t  AXI-Lite response from the downstream slave.

Behaviour:
- Interface: one clock (clk_i); reset rst_i is synchronous and active-high.
- Regbus rules: the master holds valid and all request fields stable until it sees ready. ready is a one-cycle pulse. rdata and error are valid only while ready=1.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
- IDLE:
  - On reg_req_i.valid, register addr, wdata, wstrb and write.
  - Go to WR_REQ if write=1, else RD_REQ.
  - reg_rsp_o.ready=0 in this state.
- WR_REQ:
  - aw_valid and w_valid are driven from registered flops. aw.addr = captured addr; w.data and w.strb = captured values; aw.prot = 3'b000.
  - Flags aw_done and w_done are set on the respective handshake. A valid drops the cycle after its own handshake and never re-asserts in the same transaction.
  - AW and W are independent; either may complete first, or both in the same cycle.
  - Go to WR_RESP once both are done; evaluate the flags including the current cycle's handshakes.
- WR_RESP: b_ready=1. When b_valid=1, assert reg_rsp_o.ready combinationally in that cycle, then go to IDLE.
- RD_REQ: ar_valid=1, ar.addr = captured addr, ar.prot = 3'b000. On ar_ready, go to RD_RESP.
- RD_RESP: r_ready=1. When r_valid=1:
  - reg_rsp_o.ready=1 and reg_rsp_o.rdata = r.data, both combinational;
  - go to IDLE.
- reg_rsp_o.rdata = 0 whenever it is not a read-completion cycle. Writes return rdata=0.
- Minimum latency with slave ready/valid always high:
  - write: request at cycle 0, AW/W accepted at cycle 1, ready at cycle 2;
  - read: request at cycle 0, AR at cycle 1, ready at cycle 2.
- The master drops valid after ready, so IDLE never re-accepts the completed request. A master that keeps valid high issues a new transaction one cycle after ready (back-to-back).
- All AXI valids are held stable until handshake, as AXI requires. b_ready and r_ready are 0 outside their respective RESP states.
- Reset values: state=IDLE; aw_valid, w_valid, ar_valid, b_ready, r_ready = 0; aw_done, w_done = 0; captured registers = 0; reg_rsp_o = all zero.
- Reset mid-transaction: on the clock edge with rst_i=1, return to IDLE and drop all valids, regardless of pending handshakes. Downstream is reset together with this block; an orphaned transaction is accepted system behaviour.
- wstrb=0 is forwarded unchanged; no special casing.

Optional Feature:
REG_TO_AXI_LITE_ERR_RESP_EN
- Defined: reg_rsp_o.error = 1 in the completion cycle when b.resp or r.resp is SLVERR (2'b10) or DECERR (2'b11). OKAY and EXOKAY give error=0. rdata still carries r.data.
- Undefined: reg_rsp_o.error is constant 0; resp fields are ignored.

Test Plan:
- Write, slave always ready: addr=0x100, wdata=0xDEADBEEF, wstrb=0xF -> AW/W valid at cycle 1 with prot=0; b_valid at cycle 2 -> ready at cycle 2 with rdata=0, error=0.
- Read: addr=0x204, slave returns r.data=0x12345678 two cycles after AR -> ar_valid for 1 cycle, ready pulse exactly in the r_valid cycle with rdata=0x12345678, single-cycle pulse.
- AW/W skew:
  - w_ready at cycle 1, aw_ready delayed to cycle 4 -> w_valid drops at cycle 2, aw_valid held to cycle 4, b_ready first asserted at cycle 5;
  - repeat with the skew reversed.
- Error response with REG_TO_AXI_LITE_ERR_RESP_EN: b.resp=2'b10 -> error=1; r.resp=2'b11 -> error=1 with rdata forwarded. Without the macro, both give error=0.
- Back-to-back traffic: master keeps valid high, issuing write then read at 0x8 -> second transaction's AR valid exactly 2 cycles after the first ready; no duplicate transactions.
- Reset mid-operation: rst_i=1 while in WR_REQ with aw_valid=1, ready withheld -> next cycle all valids 0, state IDLE, reg_rsp_o=0; a fresh read after reset completes normally.
